// File: rtl/vga_cmd_pkg.sv
// rtl/vga_cmd_pkg.sv - opcodes, parser states and reset configuration for vga_cmd_ctrl
package vga_cmd_pkg;

    localparam logic [7:0]  OPC_WR_CFG        = 8'h01;
    localparam logic [7:0]  OPC_WR_CHAR       = 8'h02;
    localparam logic [7:0]  OPC_RD_STATUS     = 8'h03;

    localparam logic [31:0] CFG_RESET_DEFAULT = 32'h80FC_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_CFG,
        ST_CHAR,
        ST_DONE,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/vga_cmd_ctrl.sv
// rtl/vga_cmd_ctrl.sv - SPI command sequencer with frame-synchronous configuration apply
//
// Parses framed SPI commands (opcode + payload) and drives the VGA datapath.
//   clk, rst_n           clock, synchronous active-low reset
//   cs_n                 chip select (synchronised), low = transaction open
//   rx_valid, rx_data    one-cycle strobe with a complete received byte
//   frame_start          one-cycle pulse at pixel (0,0)
//   cfg_out              live pixel-mux configuration
//   cfg_pending          shadow holds a configuration not yet applied
//   char_we/addr/data    one-cycle character-memory write
//   tx_data              status byte for the next MISO shift-out
//   busy                 a command is mid-parse
module vga_cmd_ctrl
    import vga_cmd_pkg::*;
#(
    parameter logic [31:0] CFG_RESET = CFG_RESET_DEFAULT,
    parameter int          CHAR_AW   = 5,
    parameter int          CNT_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               frame_start,
    output logic [31:0]        cfg_out,
    output logic               cfg_pending,
    output logic               char_we,
    output logic [CHAR_AW-1:0] char_addr,
    output logic               char_data,
    output logic [7:0]         tx_data,
    output logic               busy
);

    state_t             state_q, state_d;
    logic               cs_prev_q, cs_prev_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [31:0]        cfg_q, cfg_d;
    logic               pending_q, pending_d;
    logic               char_we_q, char_we_d;
    logic [CHAR_AW-1:0] char_addr_q, char_addr_d;
    logic               char_data_q, char_data_d;
    logic [7:0]         tx_q, tx_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_done;
    logic               cs_fall;

    // cs_prev resets low so a chip select already held low across reset is
    // not mistaken for a new transaction; the host must re-open it.
    assign cs_fall = cs_prev_q & ~cs_n;

    always_comb begin
        state_d     = state_q;
        cs_prev_d   = cs_n;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        pending_d   = pending_q;
        char_we_d   = 1'b0;
        char_addr_d = char_addr_q;
        char_data_d = char_data_q;
        tx_d        = tx_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        cfg_done    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d = ST_OPC;
            end
        end else if (cs_n) begin
            // Closing chip select wins over a byte arriving in the same cycle.
            state_d = ST_IDLE;
            if (state_q == ST_CFG) begin
                err_d = 1'b1;
            end
        end else if (rx_valid) begin
            case (state_q)
                ST_OPC: begin
                    case (rx_data)
                        OPC_WR_CFG: begin
                            state_d = ST_CFG;
                            idx_d   = 2'd3;
                        end
                        OPC_WR_CHAR: begin
                            state_d = ST_CHAR;
                        end
                        OPC_RD_STATUS: begin
                            state_d = ST_DONE;
                            tx_d    = {pending_q, err_q, 6'(cnt_q)};
                            err_d   = 1'b0;
                        end
                        default: begin
                            state_d = ST_DISCARD;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                ST_CFG: begin
                    shadow_d[8*idx_q +: 8] = rx_data;
                    if (idx_q == 2'd0) begin
                        pending_d = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                        state_d   = ST_DONE;
                        cfg_done  = 1'b1;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
                ST_CHAR: begin
                    char_we_d   = 1'b1;
                    char_addr_d = rx_data[CHAR_AW-1:0];
                    char_data_d = rx_data[7];
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_DONE;
                end
                default: begin
                end
            endcase
        end

        // A configuration completing on the frame_start cycle is held for the
        // next frame rather than letting the older shadow slip through.
        if (!cfg_done && frame_start && pending_q) begin
            cfg_d     = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_prev_q   <= 1'b0;
            idx_q       <= 2'd0;
            shadow_q    <= CFG_RESET;
            cfg_q       <= CFG_RESET;
            pending_q   <= 1'b0;
            char_we_q   <= 1'b0;
            char_addr_q <= '0;
            char_data_q <= 1'b0;
            tx_q        <= 8'h00;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cs_prev_q   <= cs_prev_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            pending_q   <= pending_d;
            char_we_q   <= char_we_d;
            char_addr_q <= char_addr_d;
            char_data_q <= char_data_d;
            tx_q        <= tx_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cfg_out     = cfg_q;
    assign cfg_pending = pending_q;
    assign char_we     = char_we_q;
    assign char_addr   = char_addr_q;
    assign char_data   = char_data_q;
    assign tx_data     = tx_q;
    assign busy        = (state_q == ST_OPC) || (state_q == ST_CFG) || (state_q == ST_CHAR);

endmodule

// File: tb/tb_vga_cmd_ctrl.sv
// tb/tb_vga_cmd_ctrl.sv - self-checking bench for vga_cmd_ctrl with transaction-level model
module tb_vga_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, cs_n, rx_valid, frame_start;
    logic [7:0]  rx_data;
    logic [31:0] cfg_out;
    logic        cfg_pending, char_we, char_data, busy;
    logic [4:0]  char_addr;
    logic [7:0]  tx_data;

    vga_cmd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_start(frame_start), .cfg_out(cfg_out), .cfg_pending(cfg_pending),
        .char_we(char_we), .char_addr(char_addr), .char_data(char_data),
        .tx_data(tx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state after each complete transaction.
    logic [31:0] m_cfg, m_shadow;
    logic        m_pending, m_err;
    logic [5:0]  m_cnt;
    logic [7:0]  m_tx;
    logic [7:0]  txq[$];
    logic [5:0]  exp_q[$];
    logic [5:0]  obs_q[$];

    always @(negedge clk) begin
        if (rst_n && char_we) obs_q.push_back({char_data, char_addr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        m_cfg = 32'h80FC_0000; m_shadow = 32'h80FC_0000;
        m_pending = 1'b0; m_err = 1'b0; m_cnt = 6'd0; m_tx = 8'h00;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_frame();
        if (m_pending) begin
            m_cfg = m_shadow;
            m_pending = 1'b0;
        end
    endtask

    task automatic model_txn();
        if (txq.size() == 0) return;
        case (txq[0])
            8'h01: begin
                if (txq.size() >= 5) begin
                    m_shadow = {txq[1], txq[2], txq[3], txq[4]};
                    m_pending = 1'b1;
                    m_cnt = m_cnt + 6'd1;
                end else begin
                    for (int i = 1; i < txq.size(); i++) m_shadow[8*(4-i) +: 8] = txq[i];
                    m_err = 1'b1;
                end
            end
            8'h02: begin
                if (txq.size() >= 2) begin
                    exp_q.push_back({txq[1][7], txq[1][4:0]});
                    m_cnt = m_cnt + 6'd1;
                end
            end
            8'h03: begin
                m_tx = {m_pending, m_err, m_cnt};
                m_err = 1'b0;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic run_txn();
        cs_n = 1'b0;
        tick(); tick();
        foreach (txq[i]) send_byte(txq[i]);
        cs_n = 1'b1;
        tick(); tick();
        model_txn();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; frame_start = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (cfg_out !== 32'h80FC_0000) begin errors++; $display("FAIL reset_cfg_out got %h want 80fc0000", cfg_out); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", cfg_pending); end
        checks++; if ({char_we, char_addr, char_data} !== 7'd0) begin errors++; $display("FAIL reset_char got %b want 0", {char_we, char_addr, char_data}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (3) begin pulse_frame(); model_frame(); end
        @(negedge clk);
        checks++; if (cfg_out !== m_cfg) begin errors++; $display("FAIL idle_frame_cfg got %h want %h", cfg_out, m_cfg); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL idle_frame_pending got %b want 0", cfg_pending); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL idle_char_we got %0d strobes want 0", obs_q.size()); end
    endtask

    task automatic test_cfg_write();
        do_reset();
        txq = '{8'h01, 8'h40, 8'hFC, 8'h00, 8'h00};
        cs_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_busy_opc got %b want 1", busy); end
        tick();
        foreach (txq[i]) send_byte(txq[i]);
        cs_n = 1'b1;
        tick(); tick();
        model_txn();
        @(negedge clk);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL cfg_pending got %b want 1", cfg_pending); end
        checks++; if (cfg_out !== 32'h80FC_0000) begin errors++; $display("FAIL cfg_early_apply got %h want 80fc0000", cfg_out); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_frame();
        @(negedge clk);
        checks++; if (cfg_out !== 32'h40FC_0000 || cfg_out !== m_cfg) begin errors++; $display("FAIL cfg_apply got %h want 40fc0000", cfg_out); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL cfg_apply_pending got %b want 0", cfg_pending); end
    endtask

    task automatic test_char_write();
        do_reset();
        txq = '{8'h02, 8'h93};
        run_txn();
        @(negedge clk);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL char_strobes got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== {1'b1, 5'h13}) begin errors++; $display("FAIL char_addr_data got %h want 33", obs_q[0]); end
        end
        obs_q.delete(); exp_q.delete();
        txq = '{8'h03};
        run_txn();
        @(negedge clk);
        checks++; if (tx_data !== 8'h01 || tx_data !== m_tx) begin errors++; $display("FAIL char_cnt_status got %h want 01", tx_data); end
    endtask

    task automatic test_abort();
        do_reset();
        txq = '{8'h01, 8'h12, 8'h34};
        run_txn();
        @(negedge clk);
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL abort_pending got %b want 0", cfg_pending); end
        txq = '{8'h03};
        run_txn();
        @(negedge clk);
        checks++; if (tx_data !== 8'h40 || tx_data !== m_tx) begin errors++; $display("FAIL abort_status1 got %h want 40", tx_data); end
        run_txn();
        @(negedge clk);
        checks++; if (tx_data !== 8'h00 || tx_data !== m_tx) begin errors++; $display("FAIL abort_status2 got %h want 00", tx_data); end
    endtask

    task automatic test_bad_opcode();
        do_reset();
        txq = '{8'h7F, 8'h02, 8'h05};
        cs_n = 1'b0;
        tick(); tick();
        foreach (txq[i]) send_byte(txq[i]);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_discard_busy got %b want 0", busy); end
        tick();
        cs_n = 1'b1;
        tick(); tick();
        model_txn();
        @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bad_char_we got %0d strobes want 0", obs_q.size()); end
        txq = '{8'h03};
        run_txn();
        @(negedge clk);
        checks++; if (tx_data !== 8'h40 || tx_data !== m_tx) begin errors++; $display("FAIL bad_status got %h want 40", tx_data); end
    endtask

    task automatic test_cs_rise_with_byte();
        do_reset();
        cs_n = 1'b0;
        tick(); tick();
        send_byte(8'h02);
        rx_data = 8'h85; rx_valid = 1'b1; cs_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        txq = '{8'h02};
        model_txn();
        @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL csrise_char_we got %0d strobes want 0", obs_q.size()); end
        txq = '{8'h03};
        run_txn();
        @(negedge clk);
        checks++; if (tx_data !== m_tx) begin errors++; $display("FAIL csrise_status got %h want %h", tx_data, m_tx); end
    endtask

    task automatic test_cfg_frame_collision();
        do_reset();
        txq = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_txn();
        cs_n = 1'b0;
        tick(); tick();
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        rx_data = 8'hDD; rx_valid = 1'b1; frame_start = 1'b1;
        tick();
        rx_valid = 1'b0; frame_start = 1'b0;
        tick();
        cs_n = 1'b1;
        tick(); tick();
        txq = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_txn();
        @(negedge clk);
        checks++; if (cfg_out !== 32'h80FC_0000 || cfg_out !== m_cfg) begin errors++; $display("FAIL coll_no_apply got %h want 80fc0000", cfg_out); end
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coll_pending got %b want 1", cfg_pending); end
        pulse_frame();
        model_frame();
        @(negedge clk);
        checks++; if (cfg_out !== 32'hAABB_CCDD || cfg_out !== m_cfg) begin errors++; $display("FAIL coll_next_apply got %h want aabbccdd", cfg_out); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL coll_pending_clr got %b want 0", cfg_pending); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        txq = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_txn();
        cs_n = 1'b0;
        tick(); tick();
        send_byte(8'h01); send_byte(8'h12);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        cs_n = 1'b1;
        tick(); tick();
        model_reset();
        @(negedge clk);
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending got %b want 0", cfg_pending); end
        pulse_frame();
        @(negedge clk);
        checks++; if (cfg_out !== 32'h80FC_0000) begin errors++; $display("FAIL rstmid_shadow got %h want 80fc0000", cfg_out); end
    endtask

    task automatic test_random();
        int kind, n;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            txq.delete();
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin txq.push_back(8'h01); repeat (4) txq.push_back(8'($urandom)); end
                1: begin txq.push_back(8'h01); n = $urandom_range(0, 3); repeat (n) txq.push_back(8'($urandom)); end
                2: begin txq.push_back(8'h02); n = $urandom_range(1, 2); repeat (n) txq.push_back(8'($urandom)); end
                3: txq.push_back(8'h03);
                default: begin
                    txq.push_back(8'($urandom_range(4, 255)));
                    n = $urandom_range(0, 3); repeat (n) txq.push_back(8'($urandom_range(1, 3)));
                end
            endcase
            run_txn();
            if ($urandom_range(0, 1) == 1) begin pulse_frame(); model_frame(); end
            @(negedge clk);
            checks++; if (cfg_out !== m_cfg) begin errors++; $display("FAIL rnd_cfg it %0d got %h want %h", it, cfg_out, m_cfg); end
            checks++; if (cfg_pending !== m_pending) begin errors++; $display("FAIL rnd_pending it %0d got %b want %b", it, cfg_pending, m_pending); end
            checks++; if (tx_data !== m_tx) begin errors++; $display("FAIL rnd_tx it %0d got %h want %h", it, tx_data, m_tx); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy it %0d got %b want 0", it, busy); end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rnd_char_count it %0d got %0d want %0d", it, obs_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    checks++;
                    if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd_char it %0d got %h want %h", it, obs_q[k], exp_q[k]); end
                end
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_char_write();
        test_abort();
        test_bad_opcode();
        test_cs_rise_with_byte();
        test_cfg_frame_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_cmd_ctrl.md
Name: vga_cmd_ctrl

Overview:
- Command sequencer between the SPI peripheral byte stream and the VGA datapath.
- Parses framed SPI commands and holds the 32-bit pixel-mux configuration in a shadow register.
- Swaps the shadow register into the live configuration only at frame start, so there is no mid-frame tearing.
- Issues single-cycle write strobes to the character memory and supplies a status byte for MISO readback.

Parameters:
- CFG_RESET, 32'h80FC_0000, value of live and shadow configuration after reset.
- CHAR_AW, 5, character-memory address width (4 columns x 8 rows).
- CNT_W, 6, width of the wrapping accepted-command counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- cs_n  in  1  SPI chip select, already synchronised to clk; low = transaction open
- rx_valid  in  1  one-cycle pulse, rx_data holds a complete received byte
- rx_data  in  8  received byte, MSB first on the wire
- frame_start  in  1  one-cycle pulse at the first pixel of the frame (x=0, y=0)
- cfg_out  out  32  live configuration driving pixel mux select and colours
- cfg_pending  out  1  shadow register holds an unapplied configuration
- char_we  out  1  one-cycle character-memory write strobe
- char_addr  out  CHAR_AW  character-memory write address
- char_data  out  1  character-memory write data bit
- tx_data  out  8  status byte offered to the SPI peripheral for the next shift-out
- busy  out  1  high while a command is mid-parse

Behaviour:
- Reset values:
  - cfg_out = CFG_RESET; shadow = CFG_RESET.
  - cfg_pending = 0, char_we = 0, char_addr = 0, char_data = 0.
  - tx_data = 0, busy = 0, err = 0, cmd_cnt = 0; state IDLE.
- Reset mid-command discards all partial bytes. The shadow register is reverted to CFG_RESET.
- States:
  - IDLE -> OPC when cs_n falls.
  - OPC, on rx_valid:
    - 0x01 -> CFG; byte index = 3.
    - 0x02 -> CHAR.
    - 0x03 -> DONE; same cycle, tx_data <= {cfg_pending, err, cmd_cnt}, then err clears.
    - any other byte -> DISCARD; err <= 1.
  - CFG, on rx_valid:
    - shadow[8*idx +: 8] <= rx_data, MSB byte first.
    - After idx 0: cfg_pending <= 1, cmd_cnt++ (wraps), next state DONE.
  - CHAR, on rx_valid:
    - char_we = 1 for exactly one cycle.
    - char_addr = rx_data[CHAR_AW-1:0]; char_data = rx_data[7].
    - cmd_cnt++, next state DONE.
  - DONE / DISCARD: further rx bytes are ignored.
- Any state other than IDLE -> IDLE when cs_n rises.
  - A partial CFG leaves the shadow partially written and cfg_pending unchanged.
  - A partial CFG sets err = 1 and does not increment cmd_cnt.
- busy = 1 in OPC, CFG and CHAR.
- Apply rule: on frame_start with cfg_pending = 1, cfg_out <= shadow and cfg_pending <= 0. Latency is 1 cycle after the frame_start pulse.
- Simultaneous events:
  - Last CFG byte in the same cycle as frame_start: the old shadow is not applied. The new value is applied at the following frame_start (pending remains 1).
  - cs_n rise in the same cycle as rx_valid: the byte is ignored.
- A second CFG command before frame_start overwrites the shadow; only the latest is applied.
- char_we never asserts outside CHAR, and never twice per command.

Decomposition:
- Package vga_cmd_pkg holds:
  - opcode constants OPC_WR_CFG = 8'h01, OPC_WR_CHAR = 8'h02, OPC_RD_STATUS = 8'h03;
  - the state enum;
  - the CFG_RESET default.
- No sub-module is needed. The frame-synchronous shadow/apply logic may be split into vga_cfg_shadow if reuse is wanted.

Test Plan:
- Reset, then idle frame_start pulses -> cfg_out = 32'h80FC_0000, cfg_pending = 0, char_we never asserts.
- CFG write: cs_n low, send 01 40 FC 00 00, cs_n high -> cfg_pending = 1 and cfg_out unchanged until frame_start. One cycle after frame_start, cfg_out = 32'h40FC_0000 and cfg_pending = 0.
- CHAR write: send 02 93 -> single-cycle char_we with char_addr = 5'h13, char_data = 1; cmd_cnt = 1.
- Abort: send 01 12 34, then cs_n high -> err = 1, cfg_pending = 0. A following 03 sets tx_data = 8'h40 (pending = 0, err = 1, cnt = 0); a second 03 returns 8'h00.
- Bad opcode 0x7F followed by 02 05 in the same transaction -> no char_we, err = 1, state DISCARD until cs_n rises.
- Completing CFG in the same cycle as frame_start -> no apply that frame. Applied at the next frame_start; cfg_pending stays 1 in between.
